// File: rtl/a2n_link_pkg.sv
// a2n_link_pkg: shared types and frame-length constants for the A2N multi-channel receiver.
// Optional feature macro: A2N_PARITY_EN (adds one even-parity bit per word).
`default_nettype none

package a2n_link_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } deser_state_t;

    localparam int DEF_WORD_W = 16;

`ifdef A2N_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int word_w);
        return word_w + PARITY_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/a2n_ch_deser.sv
// a2n_ch_deser: one A2N lane -- serial-to-word FSM, word FIFO and per-lane sticky error flags.
// Optional feature macro: A2N_PARITY_EN.
`default_nettype none

module a2n_ch_deser
    import a2n_link_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              data,
    input  logic              en,
    input  logic              pop,
    input  logic              status_clr,
    output logic              empty,
    output logic [WORD_W-1:0] head,
    output logic              frame_err,
    output logic              ovf_err,
    output logic              par_err
);

    localparam int FRAME_LEN = frame_len(WORD_W);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam int SH_W      = WORD_W - 1 + PARITY_BITS;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    deser_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [SH_W-1:0]   shreg;
    logic [WORD_W-1:0] done_word;
    logic              done_push;

    logic              take;
    logic              last;
    logic              frame_set;
    logic              word_ok;
    logic [WORD_W-1:0] word;

    assign take      = valid && en;
    assign last      = take && (state == ST_SHIFT) && (cnt == LAST_CNT);
    assign frame_set = (state == ST_SHIFT) && en && !valid;

`ifdef A2N_PARITY_EN
    // The parity bit is the current pin value; the word is already fully shifted in.
    assign word    = shreg;
    assign word_ok = !(^{shreg, data});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= (par_err && !status_clr) || (last && !word_ok);
        end
    end
`else
    assign word    = {shreg, data};
    assign word_ok = 1'b1;
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            done_word <= '0;
            done_push <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            done_push <= last && word_ok;
            if (last) begin
                done_word <= word;
            end
            if (take) begin
                shreg <= {shreg[SH_W-2:0], data};
            end
            frame_err <= (frame_err && !status_clr) || frame_set;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        cnt   <= CNT_W'(1);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Completion returns to IDLE with cnt=0 so a still-high VALID starts the next word.
                    if (!take || last) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              full;
    logic              wr;

    assign empty = (wptr == rptr);
    assign full  = ((wptr - rptr) == (AW+1)'(FIFO_DEPTH));
    assign wr    = done_push && (!full || pop);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr[AW-1:0]] <= done_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            ovf_err <= (ovf_err && !status_clr) || (done_push && full && !pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/a2n_link_rx_multi.sv
// a2n_link_rx_multi: N-lane A2N receiver merging per-lane word FIFOs round-robin into one tagged stream.
// Optional feature macro: A2N_PARITY_EN.
`default_nettype none

module a2n_link_rx_multi
    import a2n_link_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              SYSCLK,
    input  logic              SYSRESET,
    input  logic [NUM_CH-1:0] A2N_VALID,
    input  logic [NUM_CH-1:0] A2N_DATA,
    input  logic [NUM_CH-1:0] CH_EN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WORD_W-1:0] OUT_DATA,
    output logic [CH_W-1:0]   OUT_CH,
    input  logic              STATUS_CLR,
    output logic [NUM_CH-1:0] FRAME_ERR,
    output logic [NUM_CH-1:0] OVF_ERR,
    output logic [NUM_CH-1:0] PAR_ERR
);

    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] pop;
    logic [WORD_W-1:0] head [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        a2n_ch_deser #(
            .WORD_W     (WORD_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_deser (
            .clk        (SYSCLK),
            .rst        (SYSRESET),
            .valid      (A2N_VALID[g]),
            .data       (A2N_DATA[g]),
            .en         (CH_EN[g]),
            .pop        (pop[g]),
            .status_clr (STATUS_CLR),
            .empty      (empty[g]),
            .head       (head[g]),
            .frame_err  (FRAME_ERR[g]),
            .ovf_err    (OVF_ERR[g]),
            .par_err    (PAR_ERR[g])
        );
    end

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] win;
    logic            found;
    logic            load;
    logic            grant;
    int              idx;

    // rr_ptr holds the first lane to consider: one past the last granted lane.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && !empty[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
    end

    assign load  = !OUT_VALID || OUT_READY;
    assign grant = load && found;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = grant && (int'(win) == i);
        end
    end

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CH    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            OUT_VALID <= found;
            if (found) begin
                OUT_DATA <= head[win];
                OUT_CH   <= win;
                rr_ptr   <= (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_a2n_link_rx_multi.sv
// tb_a2n_link_rx_multi: directed and randomized stimulus with a per-channel expected-word scoreboard.
// Optional feature macro: A2N_PARITY_EN (enables the parity scenario).
`default_nettype none

module tb_a2n_link_rx_multi;

    localparam int NUM_CH = 2;
    localparam int WORD_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] a2n_valid;
    logic [NUM_CH-1:0] a2n_data;
    logic [NUM_CH-1:0] ch_en;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [0:0]        out_ch;
    logic              status_clr;
    logic [NUM_CH-1:0] frame_err;
    logic [NUM_CH-1:0] ovf_err;
    logic [NUM_CH-1:0] par_err;

    a2n_link_rx_multi #(
        .NUM_CH     (NUM_CH),
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .SYSCLK     (clk),
        .SYSRESET   (rst),
        .A2N_VALID  (a2n_valid),
        .A2N_DATA   (a2n_data),
        .CH_EN      (ch_en),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .OUT_DATA   (out_data),
        .OUT_CH     (out_ch),
        .STATUS_CLR (status_clr),
        .FRAME_ERR  (frame_err),
        .OVF_ERR    (ovf_err),
        .PAR_ERR    (par_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [WORD_W-1:0] exp0 [$];
    logic [WORD_W-1:0] exp1 [$];
    int                out_log [$];
    bit                rand_done;
    bit                frame_seen [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ch, input logic [WORD_W-1:0] w);
        if (ch == 0) exp0.push_back(w);
        else         exp1.push_back(w);
    endtask

    task automatic send_word(input int ch, input logic [WORD_W-1:0] w, input bit hold, input bit flip_par);
        for (int i = WORD_W - 1; i >= 0; i--) begin
            a2n_valid[ch] = 1'b1;
            a2n_data[ch]  = w[i];
            tick();
        end
`ifdef A2N_PARITY_EN
        a2n_valid[ch] = 1'b1;
        a2n_data[ch]  = (^w) ^ flip_par;
        tick();
`endif
        a2n_valid[ch] = hold;
    endtask

    task automatic send_partial(input int ch, input logic [WORD_W-1:0] w, input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            a2n_valid[ch] = 1'b1;
            a2n_data[ch]  = w[WORD_W-1-i];
            tick();
        end
        a2n_valid[ch] = hold;
    endtask

    task automatic pulse_clr();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 300 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
        repeat (4) tick();
        check({name, "_left_ch0"}, exp0.size(), 0);
        check({name, "_left_ch1"}, exp1.size(), 0);
    endtask

    // Monitor: every accepted output word must be the oldest outstanding word of its channel.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                out_log.push_back(int'(out_ch));
                if (out_ch == 1'b0 && exp0.size() != 0)      check("out_data_ch0", out_data, exp0.pop_front());
                else if (out_ch == 1'b1 && exp1.size() != 0) check("out_data_ch1", out_data, exp1.pop_front());
                else begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got ch%0d data %h required no word", out_ch, out_data);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        a2n_valid  = '0;
        a2n_data   = '0;
        ch_en      = '1;
        out_ready  = 1'b1;
        status_clr = 1'b0;
        repeat (3) tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_ovf_err", ovf_err, 0);
        check("reset_par_err", par_err, 0);
        rst = 1'b0;
        tick();

        // Single word: latency and one-cycle presentation.
        push_exp(0, 16'hA5C3);
        send_word(0, 16'hA5C3, 1'b0, 1'b0);
        tick();
        check("t1_valid_n1", out_valid, 0);
        tick();
        check("t1_valid_n2", out_valid, 1);
        check("t1_data", out_data, 16'hA5C3);
        check("t1_ch", out_ch, 0);
        tick();
        check("t1_valid_n3", out_valid, 0);
        drain("t1");

        // Both channels streaming back-to-back: outputs must alternate.
        out_log.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    push_exp(0, 16'h1000 + 16'(k));
                    send_word(0, 16'h1000 + 16'(k), k != 3, 1'b0);
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    push_exp(1, 16'h2000 + 16'(k));
                    send_word(1, 16'h2000 + 16'(k), k != 3, 1'b0);
                end
            end
        join
        drain("t2");
        check("t2_count", out_log.size(), 8);
        for (int i = 1; i < out_log.size(); i++) check("t2_alternate", out_log[i] != out_log[i-1], 1);
        check("t2_flags", {frame_err, ovf_err, par_err}, 0);

        // Stalled consumer: one word in the output register plus DEPTH in the FIFO, the next is dropped.
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (k < DEPTH + 1) push_exp(1, 16'h3000 + 16'(k));
            send_word(1, 16'h3000 + 16'(k), k != DEPTH + 1, 1'b0);
        end
        repeat (3) tick();
        check("t3_ovf_set", ovf_err, 2'b10);
        pulse_clr();
        check("t3_ovf_clr", ovf_err, 0);
        drain("t3");

        // VALID drop after 7 bits, then a good word.
        send_partial(0, 16'hFFFF, 7, 1'b0);
        tick();
        check("t4_frame_err", frame_err, 2'b01);
        push_exp(0, 16'h1234);
        send_word(0, 16'h1234, 1'b0, 1'b0);
        drain("t4");
        pulse_clr();
        check("t4_frame_clr", frame_err, 0);

        // Disabled channel ignores its pins entirely.
        ch_en = 2'b01;
        send_word(1, 16'h5A5A, 1'b0, 1'b0);
        send_partial(1, 16'h5A5A, 4, 1'b0);
        tick();
        check("t_dis_frame", frame_err, 0);
        ch_en = 2'b11;
        drain("t_dis");

        // Asynchronous reset with a sticky flag, a held output word, a queued word and a partial word.
        out_ready = 1'b0;
        send_partial(1, 16'hFFFF, 3, 1'b0);
        tick();
        send_word(0, 16'hCAFE, 1'b0, 1'b0);
        send_word(1, 16'hD00D, 1'b0, 1'b0);
        send_partial(0, 16'hFFFF, 5, 1'b1);
        check("t5_pre_valid", out_valid, 1);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_ch", out_ch, 0);
        check("t5_rst_flags", {frame_err, ovf_err, par_err}, 0);
        a2n_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        push_exp(0, 16'hBEEF);
        send_word(0, 16'hBEEF, 1'b0, 1'b0);
        drain("t5");

`ifdef A2N_PARITY_EN
        send_word(0, 16'h0001, 1'b0, 1'b1);
        tick();
        check("t6_par_err", par_err, 2'b01);
        push_exp(0, 16'h0001);
        send_word(0, 16'h0001, 1'b0, 1'b0);
        drain("t6");
        pulse_clr();
        check("t6_par_clr", par_err, 0);
`endif

        // Randomized traffic with aborted frames and a random consumer.
        rand_done     = 1'b0;
        frame_seen[0] = 1'b0;
        frame_seen[1] = 1'b0;
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    logic [WORD_W-1:0] w0;
                    w0 = 16'($urandom);
                    repeat ($urandom_range(0, 3)) tick();
                    if ($urandom_range(0, 7) == 0) begin
                        send_partial(0, w0, $urandom_range(1, WORD_W - 1), 1'b0);
                        frame_seen[0] = 1'b1;
                        tick();
                    end
                    push_exp(0, w0);
                    send_word(0, w0, 1'b0, 1'b0);
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    logic [WORD_W-1:0] w1;
                    w1 = 16'($urandom);
                    repeat ($urandom_range(0, 3)) tick();
                    if ($urandom_range(0, 7) == 0) begin
                        send_partial(1, w1, $urandom_range(1, WORD_W - 1), 1'b0);
                        frame_seen[1] = 1'b1;
                        tick();
                    end
                    push_exp(1, w1);
                    send_word(1, w1, 1'b0, 1'b0);
                end
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    tick();
                    if (exp0.size() == 0 && exp1.size() == 0 && total > 0 && a2n_valid == '0) begin
                        rand_done = (out_log.size() > 60);
                    end
                end
            end
        join_any
        rand_done = 1'b1;
        wait fork;
        drain("trand");
        check("trand_frame", frame_err, {frame_seen[1], frame_seen[0]});
        check("trand_ovf", ovf_err, 0);
        check("trand_par", par_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
